mem_responder: RTL and testbench

- Responder end of the CPU memory command interface.
- Accepts mem_cmd (MNONE/MREAD/MWRITE), mem_addr and write data from the control FSM/datapath, and serves a 256x16 synchronous RAM plus memory-mapped LED (write) and switch (read) registers.
- Provides registered read data, a read-valid flag, sticky error reporting and saturating access counters.
- Sits between the CPU top and the board I/O.

---
 rtl/mem_responder_pkg.sv | 48 ++++
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder_ram_sync.sv | 27 ++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: command and state encodings,
// the address map and small helper functions.
package mem_responder_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int RAM_AW = 8;
    localparam int CNT_W  = 8;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    // Must stay identical to the control FSM's command encoding.
    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_PEND = 2'b01,
        RD_HOLD = 2'b10,
        WR_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_UNMAPPED
    } region_e;

    function automatic region_e decode(input logic [ADDR_W-1:0] addr);
        region_e r;
        if (!addr[ADDR_W-1])     r = REG_RAM;
        else if (addr == LED_ADDR) r = REG_LED;
        else if (addr == SW_ADDR)  r = REG_SW;
        else                       r = REG_UNMAPPED;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory command bus: the CPU side is the master, the responder the slave.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, rd_valid
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, rd_valid
    );

endinterface

// File: rtl/mem_responder_ram_sync.sv
// Single-port-style synchronous RAM with a registered, enabled read port.
module ram_sync #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU memory command bus: RAM, LED and switch registers,
// one-cycle registered reads, sticky bus error and saturating access counters.
module mem_responder
    import mem_responder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mem_responder_if.slave     bus,
    input  logic [7:0]         sw_in,
    output logic [7:0]         leds,
    output logic               bus_err,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              bus_err_q, bus_err_d;
    logic [7:0]        leds_q, leds_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [7:0]        sw_meta_q, sw_sync_q;

    logic              start_read, start_write;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;
    cmd_e              cmd;
    region_e           req_region, acc_region;

    assign cmd        = cmd_e'(bus.mem_cmd);
    assign req_region = decode(bus.mem_addr);
    assign acc_region = decode(acc_addr_q);

    // The RAM is read as the address is accepted so its registered output is
    // ready for the RD_PEND edge, giving one cycle of total read latency.
    ram_sync #(.AW(RAM_AW), .DW(DATA_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.mem_addr[RAM_AW-1:0]),
        .wdata (bus.write_data),
        .re    (ram_re),
        .raddr (bus.mem_addr[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        read_data_d = read_data_q;
        rd_valid_d  = rd_valid_q;
        bus_err_d   = bus_err_q;
        leds_d      = leds_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        start_read  = 1'b0;
        start_write = 1'b0;

        if (cmd == MILLEGAL) begin
            bus_err_d  = 1'b1;
            rd_valid_d = 1'b0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    start_read  = (cmd == MREAD);
                    start_write = (cmd == MWRITE);
                end
                RD_PEND: begin
                    unique case (acc_region)
                        REG_RAM: read_data_d = ram_rdata;
                        REG_SW:  read_data_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
                        default: begin
                            read_data_d = '0;
                            bus_err_d   = 1'b1;
                        end
                    endcase
                    rd_valid_d = 1'b1;
                    rd_count_d = sat_inc(rd_count_q);
                    state_d    = RD_HOLD;
                end
                RD_HOLD: begin
                    start_read  = (cmd == MREAD) && (bus.mem_addr != acc_addr_q);
                    start_write = (cmd == MWRITE);
                    if (cmd == MNONE) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                WR_DONE: begin
                    start_read  = (cmd == MREAD);
                    start_write = (cmd == MWRITE) &&
                                  ((bus.mem_addr != acc_addr_q) ||
                                   (bus.write_data != acc_data_q));
                    if (cmd == MNONE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (start_read) begin
            acc_addr_d = bus.mem_addr;
            ram_re     = 1'b1;
            rd_valid_d = 1'b0;
            state_d    = RD_PEND;
        end

        // A write to a non-writable address only raises the error flag.
        if (start_write) begin
            if (req_region == REG_RAM || req_region == REG_LED) begin
                ram_we     = (req_region == REG_RAM);
                if (req_region == REG_LED) leds_d = bus.write_data[7:0];
                wr_count_d = sat_inc(wr_count_q);
                acc_addr_d = bus.mem_addr;
                acc_data_d = bus.write_data;
                rd_valid_d = 1'b0;
                state_d    = WR_DONE;
            end else begin
                bus_err_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_addr_q  <= '0;
            acc_data_q  <= '0;
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            leds_q      <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
            read_data_q <= read_data_d;
            rd_valid_q  <= rd_valid_d;
            bus_err_q   <= bus_err_d;
            leds_q      <= leds_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            sw_meta_q   <= sw_in;
            sw_sync_q   <= sw_meta_q;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign leds          = leds_q;
    assign bus_err       = bus_err_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [7:0]  sw_in;
    logic [7:0]  leds;
    logic        bus_err;
    logic [7:0]  rd_count;
    logic [7:0]  wr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_responder_if bus();

    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sw_in    (sw_in),
        .leds     (leds),
        .bus_err  (bus_err),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "a read is pending / a read result is being held /
    // the last committed write" facts, updated once per clock.
    logic [15:0] m_mem [256];
    logic [15:0] m_rdata;
    logic        m_rvalid, m_err;
    logic [7:0]  m_leds, m_rdc, m_wrc, m_s1, m_s2;
    logic        m_pend, m_hold, m_lw;
    logic [8:0]  m_pend_addr, m_hold_addr, m_lw_addr;
    logic [15:0] m_lw_data;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic model_step();
        logic [1:0]  c;
        logic [8:0]  a;
        logic [15:0] d;
        logic [7:0]  sw_now;
        c = bus.mem_cmd;
        a = bus.mem_addr;
        d = bus.write_data;
        sw_now = m_s2;
        m_s2 = m_s1;
        m_s1 = sw_in;
        if (c == 2'b11) begin
            m_err = 1'b1; m_rvalid = 1'b0;
            m_pend = 1'b0; m_hold = 1'b0; m_lw = 1'b0;
        end else if (m_pend) begin
            if (a < 9'h100 || m_pend_addr < 9'h100) begin end
            if (m_pend_addr < 9'h100)       m_rdata = m_mem[m_pend_addr[7:0]];
            else if (m_pend_addr == 9'h140) m_rdata = {8'h00, sw_now};
            else begin m_rdata = 16'h0000; m_err = 1'b1; end
            m_rvalid = 1'b1;
            m_rdc = inc8(m_rdc);
            m_pend = 1'b0;
            m_hold = 1'b1; m_hold_addr = m_pend_addr;
        end else if (c == 2'b01) begin
            if (!(m_hold && a == m_hold_addr)) begin
                m_rvalid = 1'b0;
                m_pend = 1'b1; m_pend_addr = a;
                m_hold = 1'b0; m_lw = 1'b0;
            end
        end else if (c == 2'b10) begin
            if (m_lw && a == m_lw_addr && d == m_lw_data) begin
            end else if (a < 9'h100 || a == 9'h100) begin
                if (a < 9'h100) m_mem[a[7:0]] = d;
                else            m_leds = d[7:0];
                m_wrc = inc8(m_wrc);
                m_rvalid = 1'b0; m_hold = 1'b0;
                m_lw = 1'b1; m_lw_addr = a; m_lw_data = d;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_rvalid = 1'b0; m_hold = 1'b0; m_lw = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_rdata = 16'h0; m_rvalid = 1'b0; m_err = 1'b0;
                m_leds = 8'h0; m_rdc = 8'h0; m_wrc = 8'h0;
                m_s1 = 8'h0; m_s2 = 8'h0;
                m_pend = 1'b0; m_hold = 1'b0; m_lw = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_read_data", bus.read_data, m_rdata);
            check("cyc_rd_valid", {15'b0, bus.rd_valid}, {15'b0, m_rvalid});
            check("cyc_leds", {8'b0, leds}, {8'b0, m_leds});
            check("cyc_bus_err", {15'b0, bus_err}, {15'b0, m_err});
            check("cyc_rd_count", {8'b0, rd_count}, {8'b0, m_rdc});
            check("cyc_wr_count", {8'b0, wr_count}, {8'b0, m_wrc});
        end
    end

    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        @(posedge clk);
        #2;
    endtask

    localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_ILL = 2'b11;

    initial begin
        reset = 1'b1;
        sw_in = 8'h00;
        bus.mem_cmd = C_NONE; bus.mem_addr = '0; bus.write_data = '0;
        step(C_NONE, 9'h000, 16'h0);
        step(C_NONE, 9'h000, 16'h0);
        check("rst_read_data", bus.read_data, 16'h0000);
        check("rst_rd_valid", {15'b0, bus.rd_valid}, 16'h0);
        check("rst_leds", {8'b0, leds}, 16'h0);
        check("rst_bus_err", {15'b0, bus_err}, 16'h0);
        check("rst_counts", {rd_count, wr_count}, 16'h0);
        reset = 1'b0;

        // Preload RAM[5], then reset: RAM contents must survive reset.
        step(C_WR, 9'h005, 16'hABCD);
        step(C_NONE, 9'h000, 16'h0);
        reset = 1'b1;
        step(C_NONE, 9'h000, 16'h0);
        reset = 1'b0;
        check("preload_wr_cleared", {8'b0, wr_count}, 16'h0);

        // 1: two-cycle read
        step(C_RD, 9'h005, 16'h0);
        check("t1_valid_c1", {15'b0, bus.rd_valid}, 16'h0);
        step(C_RD, 9'h005, 16'h0);
        check("t1_data", bus.read_data, 16'hABCD);
        check("t1_valid_c2", {15'b0, bus.rd_valid}, 16'h1);
        check("t1_rd_count", {8'b0, rd_count}, 16'd1);
        step(C_NONE, 9'h000, 16'h0);

        // 2: held write counts once
        repeat (3) step(C_WR, 9'h010, 16'h1234);
        check("t2_wr_count", {8'b0, wr_count}, 16'd1);
        step(C_RD, 9'h010, 16'h0);
        step(C_RD, 9'h010, 16'h0);
        check("t2_data", bus.read_data, 16'h1234);
        step(C_NONE, 9'h000, 16'h0);

        // 3: LED and switch registers
        step(C_WR, 9'h100, 16'h00A5);
        check("t3_leds", {8'b0, leds}, 16'h00A5);
        step(C_NONE, 9'h000, 16'h0);
        sw_in = 8'h3C;
        repeat (2) step(C_NONE, 9'h000, 16'h0);
        step(C_RD, 9'h140, 16'h0);
        step(C_RD, 9'h140, 16'h0);
        check("t3_sw_data", bus.read_data, 16'h003C);
        step(C_NONE, 9'h000, 16'h0);

        // 5: back-to-back reads of different addresses
        step(C_WR, 9'h001, 16'h1111);
        step(C_WR, 9'h002, 16'h2222);
        check("t5_wr_count", {8'b0, wr_count}, 16'd4);
        step(C_RD, 9'h001, 16'h0);
        step(C_RD, 9'h001, 16'h0);
        check("t5_data1", bus.read_data, 16'h1111);
        step(C_RD, 9'h002, 16'h0);
        check("t5_valid_drop", {15'b0, bus.rd_valid}, 16'h0);
        step(C_RD, 9'h002, 16'h0);
        check("t5_data2", bus.read_data, 16'h2222);
        check("t5_valid2", {15'b0, bus.rd_valid}, 16'h1);
        check("t5_rd_count", {8'b0, rd_count}, 16'd5);

        // Write immediately followed by read of the same address
        step(C_WR, 9'h020, 16'hBEEF);
        step(C_RD, 9'h020, 16'h0);
        step(C_RD, 9'h020, 16'h0);
        check("wf_data", bus.read_data, 16'hBEEF);

        // 4: unmapped read, sticky error, bad write, LED read
        step(C_RD, 9'h1F0, 16'h0);
        step(C_RD, 9'h1F0, 16'h0);
        check("t4_data", bus.read_data, 16'h0000);
        check("t4_valid", {15'b0, bus.rd_valid}, 16'h1);
        check("t4_err", {15'b0, bus_err}, 16'h1);
        check("t4_rd_count", {8'b0, rd_count}, 16'd7);
        step(C_NONE, 9'h000, 16'h0);
        step(C_WR, 9'h030, 16'h5555);
        check("t4_err_sticky", {15'b0, bus_err}, 16'h1);
        step(C_WR, 9'h140, 16'h7777);
        check("t4_sw_write_nocount", {8'b0, wr_count}, 16'd6);
        step(C_NONE, 9'h000, 16'h0);
        step(C_RD, 9'h100, 16'h0);
        step(C_RD, 9'h100, 16'h0);
        check("t4_led_read", bus.read_data, 16'h0000);
        check("t4_led_rd_count", {8'b0, rd_count}, 16'd8);
        step(C_NONE, 9'h000, 16'h0);

        // Write counter saturation
        for (int i = 0; i < 300; i++) step(C_WR, 9'h040, 16'(i));
        check("sat_wr_count", {8'b0, wr_count}, 16'h00FF);
        step(C_NONE, 9'h000, 16'h0);

        // 6: asynchronous reset while holding a read, then illegal command
        step(C_RD, 9'h005, 16'h0);
        step(C_RD, 9'h005, 16'h0);
        check("t6_pre_valid", {15'b0, bus.rd_valid}, 16'h1);
        reset = 1'b1;
        #1;
        check("t6_async_valid", {15'b0, bus.rd_valid}, 16'h0);
        check("t6_async_data", bus.read_data, 16'h0000);
        check("t6_async_counts", {rd_count, wr_count}, 16'h0000);
        check("t6_async_leds", {8'b0, leds}, 16'h0);
        step(C_RD, 9'h005, 16'h0);
        reset = 1'b0;
        step(C_ILL, 9'h005, 16'hFFFF);
        check("t6_ill_err", {15'b0, bus_err}, 16'h1);
        check("t6_ill_valid", {15'b0, bus.rd_valid}, 16'h0);
        check("t6_ill_wr_count", {8'b0, wr_count}, 16'h0);
        step(C_NONE, 9'h000, 16'h0);
        step(C_RD, 9'h005, 16'h0);
        step(C_RD, 9'h005, 16'h0);
        check("t6_ram_kept", bus.read_data, 16'hABCD);
        step(C_NONE, 9'h000, 16'h0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
